fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Multi-cycle instruction-fetch controller for the single-cycle core's byte-wide instruction memory.
//  Owns the PC and issues four byte reads per instruction at PC+0..PC+3.
//  Assembles the bytes little-endian into a 32-bit word and hands it to decode with a valid/ready handshake.
//  Branch/jump redirects from execute abort the fetch in flight and restart at the new PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  ADDR_WIDTH  32             width of PC and mem_addr
// PORTS
//  clk             in   1           rising-edge clock
//  reset           in   1           synchronous, active-high reset
//  run             in   1           1 = fetch continuously; 0 = stop after the current instruction
//  mem_rd_en       out  1           byte-read request, held until mem_ready
//  mem_addr        out  ADDR_WIDTH  byte address of the current request
//  mem_rdata       in   8           read data, valid in the cycle mem_ready=1
//  mem_ready       in   1           read completes this cycle (only meaningful when mem_rd_en=1)
//  instr           out  32          assembled instruction {b3,b2,b1,b0}
//  instr_pc        out  ADDR_WIDTH  PC of the word on instr
//  instr_valid     out  1           instr/instr_pc valid
//  instr_ready     in   1           decode accepts instr this cycle
//  redirect_valid  in   1           load redirect_pc and discard in-flight work
//  redirect_pc     in   ADDR_WIDTH  new PC; bits [1:0] are forced to 0
//  busy            out  1           1 in FETCH or HOLD
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=IDLE, byte_cnt=0, mem_rd_en=0, mem_addr=0, instr=0, instr_pc=0,
//   instr_valid=0, busy=0. Reset in any state, including mid-fetch, abandons everything in the next cycle.
//  States:
//   IDLE  - no requests issued.
//           run=1 -> FETCH with byte_cnt=0.
//   FETCH - mem_rd_en=1, mem_addr=pc+byte_cnt.
//           On mem_ready: instr[8*byte_cnt+:8] <= mem_rdata and byte_cnt++.
//           On the 4th byte (byte_cnt==3 && mem_ready): instr_pc<=pc, pc<=pc+4, byte_cnt<=0, -> HOLD.
//   HOLD  - instr_valid=1, mem_rd_en=0; instr and instr_pc are stable while instr_ready=0.
//           instr_ready=1 -> FETCH if run=1, else IDLE.
//  Latency: with mem_ready tied 1, instr_valid rises 4 cycles after entering FETCH. With instr_ready tied 1,
//   throughput is one instruction per 5 cycles. Each mem_ready wait cycle adds one cycle.
//  Redirect has priority over everything except reset. On redirect_valid in any state:
//   pc <= {redirect_pc[AW-1:2],2'b00}, byte_cnt <= 0, instr_valid <= 0 next cycle.
//   Next state is FETCH if run=1, else IDLE.
//   Redirect in FETCH: the partial word is discarded. A mem_ready arriving in the same cycle is ignored.
//   Redirect in HOLD together with instr_ready=1: the transfer counts as completed. The next word fetched
//   comes from the redirect target.
//  run=0 while in FETCH: the current word completes into HOLD. No new fetch starts after the handshake.
//  PC arithmetic is modulo 2^ADDR_WIDTH: pc=FFFF_FFFC fetches FFFF_FFFC..FFFF_FFFF and the next pc is 0.
//   Byte addresses pc+byte_cnt never wrap inside one word because pc is word-aligned.
//  mem_addr changes only when a byte completes or on redirect/reset, never while waiting on mem_ready.
//  busy = (state != IDLE).
// TESTING
//  1. Reset, run=1, mem_ready=1, mem bytes 08 00 00 FC at 0..3 -> instr_valid on cycle 4, instr=FC000008, instr_pc=0.
//  2. instr_ready=0 for 3 cycles in HOLD -> instr and instr_pc stable, mem_rd_en=0. Then ready=1 -> FETCH at mem_addr=4.
//  3. mem_ready low 2 cycles on byte 1 -> mem_addr held at 1 with rd_en=1. Word completes 2 cycles later than test 1.
//  4. redirect_valid with redirect_pc=0x13 during byte 2 -> next mem_addr=0x10.
//     The resulting word is bytes 0x10..0x13 and instr_pc=0x10.
//  5. RESET_PC=FFFF_FFFC -> one word fetched from FFFF_FFFC..FFFF_FFFF, then the next fetch starts at mem_addr=0.
//  6. run=0 mid-fetch -> word delivered, then IDLE with busy=0. Reset asserted during FETCH -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Purpose : instruction-fetch sequencer; four byte reads per word, little-endian assembly, decode handshake.
// Latency : word presented 4 cycles after entering FETCH with zero-wait memory; +1 cycle per mem_ready wait.
// Backpressure: HOLD keeps instr/instr_pc stable until instr_ready; no new reads are issued meanwhile.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   run                        1 = fetch continuously, 0 = stop after the current word is handed off
//   mem_rd_en/mem_addr         byte-read request toward instruction memory (held until mem_ready)
//   mem_rdata/mem_ready        byte return; data valid in the cycle mem_ready=1
//   instr/instr_pc/instr_valid assembled word, its PC, and valid toward decode
//   instr_ready                decode accepts the word this cycle
//   redirect_valid/redirect_pc branch/jump restart; low two PC bits are dropped
//   busy                       high whenever the sequencer is not idle
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [1:0]            byte_cnt, byte_cnt_nxt;
  logic [31:0]           instr_q, instr_nxt;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_nxt;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      byte_cnt   <= 2'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      byte_cnt   <= byte_cnt_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
    end
  end

  // Next-state logic. Redirect pre-empts every state; any byte returning in
  // the same cycle is dropped because the partial word belongs to the old path.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    byte_cnt_nxt = byte_cnt;
    instr_nxt    = instr_q;
    instr_pc_nxt = instr_pc_q;

    if (redirect_valid) begin
      // Masking (rather than slicing) keeps the target word-aligned.
      pc_nxt       = redirect_pc & ~ADDR_WIDTH'(3);
      byte_cnt_nxt = 2'd0;
      state_nxt    = run ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state_nxt    = FETCH;
            byte_cnt_nxt = 2'd0;
          end
        end

        FETCH: begin
          if (mem_ready) begin
            instr_nxt[8*byte_cnt +: 8] = mem_rdata;
            // 2-bit counter rolls 3 -> 0 on the last byte by itself.
            byte_cnt_nxt = byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              instr_pc_nxt = pc;
              pc_nxt       = pc + ADDR_WIDTH'(4);
              state_nxt    = HOLD;
            end
          end
        end

        HOLD: begin
          if (instr_ready) begin
            state_nxt = run ? FETCH : IDLE;
          end
        end

        default: begin
          state_nxt    = IDLE;
          byte_cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so the request address only
  // moves when byte_cnt or pc moves (byte completion, redirect, reset).
  always_comb begin
    mem_rd_en   = (state == FETCH);
    // pc is word-aligned, so adding byte_cnt never carries past bit 1.
    mem_addr    = (state == FETCH) ? (pc | ADDR_WIDTH'(byte_cnt)) : '0;
    instr_valid = (state == HOLD);
    busy        = (state != IDLE);
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose : directed checks of fetch_sequencer against hand-computed words and addresses.
// Latency : n/a (bench).
// Backpressure: n/a (bench drives instr_ready and mem_ready directly).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready, instr_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_rd_en, instr_valid, busy;
  logic [31:0] mem_addr, instr, instr_pc;
  logic [7:0]  mem_rdata;

  logic        reset2, run2, instr_ready2;
  logic        mem_rd_en2, instr_valid2, busy2;
  logic [31:0] mem_addr2, instr2, instr_pc2;
  logic [7:0]  mem_rdata2;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  // Memory image: fixed bytes at 0..3, elsewhere a simple address-derived pattern.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   mem_byte = 8'h08;
      32'd1:   mem_byte = 8'h00;
      32'd2:   mem_byte = 8'h00;
      32'd3:   mem_byte = 8'hFC;
      default: mem_byte = (a[7:0] + 8'h30) ^ a[31:24];
    endcase
  endfunction

  assign mem_rdata  = mem_byte(mem_addr);
  assign mem_rdata2 = mem_byte(mem_addr2);

  fetch_sequencer #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  fetch_sequencer #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset2), .run(run2),
    .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2), .mem_ready(1'b1),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(instr_ready2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts clock edges until the selected instance shows instr_valid (bounded).
  task automatic wait_valid(input bit sel, output int cnt);
    cnt = 0;
    while (!(sel ? instr_valid2 : instr_valid) && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b1; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    reset2 = 1'b1; run2 = 1'b0; instr_ready2 = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_busy",  busy, 0);
    chk("rst_rden",  mem_rd_en, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ipc",   instr_pc, 0);
    chk("rst_valid", instr_valid, 0);

    // Test 1: first word with zero-wait memory
    reset = 1'b0; run = 1'b1;
    tick();
    chk("t1_rden", mem_rd_en, 1);
    chk("t1_addr", mem_addr, 0);
    wait_valid(1'b0, n);
    chk("t1_lat",   n, 4);
    chk("t1_instr", instr, 32'hFC00_0008);
    chk("t1_ipc",   instr_pc, 0);

    // Test 2: decode stalls for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr, 32'hFC00_0008);
      chk("t2_ipc",   instr_pc, 0);
      chk("t2_rden",  mem_rd_en, 0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t2_valid_drop", instr_valid, 0);
    chk("t2_rden",       mem_rd_en, 1);
    chk("t2_addr",       mem_addr, 32'h4);

    // Test 3: two wait states on byte 1
    tick();
    chk("t3_addr_b1", mem_addr, 32'h5);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_addr_hold", mem_addr, 32'h5);
      chk("t3_rden_hold", mem_rd_en, 1);
    end
    mem_ready = 1'b1;
    wait_valid(1'b0, n);
    chk("t3_lat",   n, 3);
    chk("t3_instr", instr, 32'h3736_3534);
    chk("t3_ipc",   instr_pc, 32'h4);

    // Test 4: redirect to 0x13 during byte 2
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t4_addr_start", mem_addr, 32'h8);
    tick(); tick();
    chk("t4_addr_b2", mem_addr, 32'hA);
    redirect_valid = 1'b1; redirect_pc = 32'h13;
    tick();
    redirect_valid = 1'b0;
    chk("t4_addr_redir", mem_addr, 32'h10);
    chk("t4_rden",       mem_rd_en, 1);
    wait_valid(1'b0, n);
    chk("t4_lat",   n, 4);
    chk("t4_instr", instr, 32'h4342_4140);
    chk("t4_ipc",   instr_pc, 32'h10);

    // Test 6a: run dropped mid-fetch
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t6_addr_start", mem_addr, 32'h14);
    tick();
    run = 1'b0;
    wait_valid(1'b0, n);
    chk("t6_lat",   n, 3);
    chk("t6_instr", instr, 32'h4746_4544);
    chk("t6_ipc",   instr_pc, 32'h14);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t6_busy",  busy, 0);
    chk("t6_rden",  mem_rd_en, 0);
    chk("t6_valid", instr_valid, 0);
    tick();
    chk("t6_busy_stay", busy, 0);

    // Test 6b: reset during FETCH
    run = 1'b1;
    tick();
    chk("t6_restart_addr", mem_addr, 32'h18);
    tick();
    reset = 1'b1;
    tick();
    chk("t6r_busy",  busy, 0);
    chk("t6r_rden",  mem_rd_en, 0);
    chk("t6r_addr",  mem_addr, 0);
    chk("t6r_instr", instr, 0);
    chk("t6r_ipc",   instr_pc, 0);
    chk("t6r_valid", instr_valid, 0);
    reset = 1'b0;
    tick();
    chk("t6r_pc_reload", mem_addr, 0);
    wait_valid(1'b0, n);
    chk("t6r_lat",   n, 4);
    chk("t6r_instr", instr, 32'hFC00_0008);

    // Redirect coinciding with a HOLD handshake
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("rh_addr",  mem_addr, 32'h20);
    chk("rh_valid", instr_valid, 0);
    chk("rh_busy",  busy, 1);
    wait_valid(1'b0, n);
    chk("rh_lat",   n, 4);
    chk("rh_instr", instr, 32'h5352_5150);
    chk("rh_ipc",   instr_pc, 32'h20);

    // Test 5: PC wrap from RESET_PC = FFFF_FFFC
    reset2 = 1'b0; run2 = 1'b1;
    tick();
    chk("t5_addr",  mem_addr2, 32'hFFFF_FFFC);
    wait_valid(1'b1, n);
    chk("t5_lat",   n, 4);
    chk("t5_instr", instr2, 32'hD0D1_D2D3);
    chk("t5_ipc",   instr_pc2, 32'hFFFF_FFFC);
    instr_ready2 = 1'b1;
    tick();
    instr_ready2 = 1'b0;
    chk("t5_wrap_addr", mem_addr2, 32'h0);
    chk("t5_wrap_rden", mem_rd_en2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
